// File: rtl/audio_pkg.sv
// Shared types and defaults for the audio serial-to-parallel path.
package audio_pkg;

    localparam int DEF_WORD_W     = 16;
    localparam int DEF_FIFO_DEPTH = 4;

    typedef logic [DEF_WORD_W-1:0] audio_word_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } deser_state_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy output.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_en;
    logic             pop_en;

    assign valid   = (level != '0);
    assign full    = (level == LVL_W'(DEPTH));
    assign pop_en  = pop && valid;
    assign push_en = push && (!full || pop_en);
    // Output forced to zero while empty so it reads 0 straight out of reset.
    assign rd_data = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clock) begin
        if (push_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_en, pop_en})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/deserializer.sv
// Serial audio deserializer: shifts MSB-first bits into words and buffers them
// in a FWFT FIFO. Handshake: a word moves on any edge where word_valid && word_ready.
module deserializer
    import audio_pkg::*;
#(
    parameter int WORD_W     = DEF_WORD_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic                          audio_data,
    output logic [WORD_W-1:0]             word_out,
    output logic                          word_valid,
    input  logic                          word_ready,
    output logic                          done,
    output logic [$clog2(WORD_W)-1:0]     bit_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overrun,
    input  logic                          overrun_clear,
    output logic                          state_dbg
);

    localparam int                CNT_W    = $clog2(WORD_W);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WORD_W - 1);

    deser_state_t      state;
    deser_state_t      state_nxt;
    logic [WORD_W-2:0] shreg;
    logic              shift_en;
    logic              push;
    logic              fifo_full;
    logic [WORD_W-1:0] push_word;

    assign state_dbg = state;
    assign push_word = {shreg, audio_data};

    // Sampling is gated by enable alone so the first high cycle already captures bit 0.
    always_comb begin
        state_nxt = state;
        shift_en  = 1'b0;
        push      = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = SHIFT;
                    shift_en  = 1'b1;
                end
            end
            SHIFT: begin
                if (enable) begin
                    shift_en = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        push = shift_en && (bit_count == LAST_BIT);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shreg     <= '0;
            bit_count <= '0;
            done      <= 1'b0;
        end else begin
            done <= push;
            if (!shift_en) begin
                shreg     <= '0;
                bit_count <= '0;
            end else begin
                shreg     <= push_word[WORD_W-2:0];
                bit_count <= push ? '0 : bit_count + 1'b1;
            end
        end
    end

    // A set on the same edge as a clear wins so no drop event is lost.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overrun <= 1'b0;
        end else if (push && fifo_full && !(word_valid && word_ready)) begin
            overrun <= 1'b1;
        end else if (overrun_clear) begin
            overrun <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .wr_data (push_word),
        .pop     (word_ready),
        .rd_data (word_out),
        .valid   (word_valid),
        .full    (fifo_full),
        .level   (fifo_level)
    );

endmodule

// File: doc/deserializer.md
DESERIALIZER -- requirements
Module: deserializer

Interface
REQ-001 The block SHALL take parameter WORD_W, default 16, bits per assembled word.
REQ-002 The block SHALL take parameter FIFO_DEPTH, default 4, output word buffer entries (power of two, >=2).
REQ-003 The block SHALL have port clock  input  1  sole clock, all state updates on rising edge.
REQ-004 The block SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port enable  input  1  high = sample audio_data every cycle; low = idle and discard partial word.
REQ-006 The block SHALL have port audio_data  input  1  serial bit stream, MSB of each word first.
REQ-007 The block SHALL have port word_out  output  WORD_W  head-of-buffer word, valid when word_valid high.
REQ-008 The block SHALL have port word_valid  output  1  buffer not empty.
REQ-009 The block SHALL have port word_ready  input  1  consumer accepts word_out this cycle.
REQ-010 The block SHALL have port done  output  1  one-cycle pulse per completed word.
REQ-011 The block SHALL have port bit_count  output  $clog2(WORD_W)  bits sampled into current word.
REQ-012 The block SHALL have port fifo_level  output  $clog2(FIFO_DEPTH)+1  buffered word count.
REQ-013 The block SHALL have port overrun  output  1  sticky, completed word dropped because buffer full.
REQ-014 The block SHALL have port overrun_clear  input  1  synchronous clear of overrun.

Function
REQ-015 FSM SHALL have states IDLE and SHIFT; IDLE->SHIFT when enable=1, SHIFT->IDLE when enable=0.
REQ-016 In SHIFT with enable=1, each edge SHALL shift left: shreg <= {shreg[WORD_W-2:0], audio_data}; bit_count increments.
REQ-017 IDLE sampling SHALL start in the same cycle enable is first seen high (no dead cycle).
REQ-018 On the edge sampling bit index WORD_W-1, the block SHALL push {shreg[WORD_W-2:0], audio_data} into the buffer and wrap bit_count to 0.
REQ-019 done SHALL be registered, high exactly the cycle after the push edge, low otherwise.
REQ-020 Consecutive words with enable held high SHALL be back-to-back, no gap cycles; done period = WORD_W cycles.
REQ-021 enable=0 SHALL clear bit_count and shreg on the next edge; partial word discarded, no push, no done.
REQ-022 Buffer SHALL be first-word-fall-through: word pushed into empty buffer at edge N is on word_out with word_valid=1 after edge N.
REQ-023 Pop SHALL occur on any edge with word_valid=1 and word_ready=1; word_ready with word_valid=0 has no effect.
REQ-024 Push into full buffer with simultaneous pop SHALL be accepted; fifo_level unchanged.
REQ-025 Push into full buffer without pop SHALL drop the new word, keep contents, set overrun; done still pulses.
REQ-026 overrun_clear SHALL clear overrun; simultaneous set and clear SHALL leave overrun=1.
REQ-027 Buffer pointers SHALL wrap modulo FIFO_DEPTH; fifo_level SHALL range 0..FIFO_DEPTH.
REQ-028 word_out SHALL hold its value while word_valid=1 and word_ready=0.

Reset
REQ-029 reset_n=0 SHALL asynchronously force state IDLE, shreg=0, bit_count=0, done=0, buffer empty, word_valid=0, word_out=0, fifo_level=0, overrun=0.
REQ-030 Reset mid-word or with buffered words SHALL discard all; first sample after release is bit 0 of a new word.

Structure
REQ-031 Shared package audio_pkg SHALL hold WORD_W default constant, typedef audio_word_t, and the deser_state_t enum.
REQ-032 The buffer SHALL be one sub-module, sync_fifo (FWFT, parameterised width/depth, level output); shift/FSM logic stays in deserializer.

Verification
REQ-033 enable=1, stream 16'hA5C3 MSB first -> done pulse cycle 17, word_out=16'hA5C3, word_valid=1, fifo_level=1.
REQ-034 Three back-to-back words 16'h0001,16'h8000,16'hFFFF, word_ready=1 -> popped in order, done every 16 cycles, no gaps.
REQ-035 enable dropped after 9 bits then 16 bits of 16'h1234 -> only 16'h1234 delivered, one done pulse.
REQ-036 word_ready=0, 5 words into depth-4 buffer -> fifo_level=4, overrun=1, first 4 words intact; overrun_clear -> 0.
REQ-037 Buffer full, 5th word completes with word_ready=1 same edge -> no overrun, level stays 4, order preserved.
REQ-038 reset_n low at bit 7 with 2 words buffered -> all outputs 0 immediately; next 16 bits of 16'hBEEF yield 16'hBEEF.
